// File: rtl/mem_stage.sv
// LC-3b memory stage: runs LDR/LDB/LDI/STR/STB/STI against a handshaked data memory
// and registers a single writeback bundle per retired instruction.
module mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [3:0]  opcode,
    input  logic [15:0] addr,
    input  logic [15:0] store_data,
    input  logic [15:0] ex_result,
    input  logic [2:0]  dest_in,
    input  logic        dmem_resp,
    input  logic [15:0] dmem_rdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    output logic [1:0]  dmem_byte_enable,
    output logic        stall,
    output logic        wb_valid,
    output logic [2:0]  wb_dest,
    output logic [15:0] wb_data,
    output logic        wb_regwrite
);

    localparam logic [3:0] OpBr   = 4'b0000;
    localparam logic [3:0] OpLdb  = 4'b0010;
    localparam logic [3:0] OpStb  = 4'b0011;
    localparam logic [3:0] OpLdr  = 4'b0110;
    localparam logic [3:0] OpStr  = 4'b0111;
    localparam logic [3:0] OpLdi  = 4'b1010;
    localparam logic [3:0] OpSti  = 4'b1011;
    localparam logic [3:0] OpJmp  = 4'b1100;
    localparam logic [3:0] OpTrap = 4'b1111;

    typedef enum logic [1:0] {StIdle, StAcc1, StAcc2} state_e;

    state_e      state_q;
    logic [15:0] ptr_q;
    logic        wb_valid_q;
    logic [2:0]  wb_dest_q;
    logic [15:0] wb_data_q;
    logic        wb_regwrite_q;

    logic is_ldr, is_ldb, is_ldi, is_str, is_stb, is_sti;
    logic is_mem, is_word, is_ind, is_load, is_store, no_regwrite;
    logic [15:0] ldb_byte;

    assign is_ldr      = (opcode == OpLdr);
    assign is_ldb      = (opcode == OpLdb);
    assign is_ldi      = (opcode == OpLdi);
    assign is_str      = (opcode == OpStr);
    assign is_stb      = (opcode == OpStb);
    assign is_sti      = (opcode == OpSti);
    assign is_load     = is_ldr | is_ldb | is_ldi;
    assign is_store    = is_str | is_stb | is_sti;
    assign is_mem      = is_load | is_store;
    assign is_word     = is_ldr | is_ldi | is_str | is_sti;
    assign is_ind      = is_ldi | is_sti;
    assign no_regwrite = (opcode == OpBr) | (opcode == OpJmp) | (opcode == OpTrap) | is_store;
    assign ldb_byte    = addr[0] ? {8'h00, dmem_rdata[15:8]} : {8'h00, dmem_rdata[7:0]};

    // Strobes decode from state plus the held upstream inputs; IDLE drives everything low,
    // so the asynchronous reset clears them immediately.
    always_comb begin
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_addr        = 16'h0000;
        dmem_wdata       = 16'h0000;
        dmem_byte_enable = 2'b00;
        stall            = 1'b0;
        unique case (state_q)
            StIdle: begin
                stall = rst_n & valid_in & is_mem;
            end
            StAcc1: begin
                dmem_addr = is_word ? (addr & 16'hFFFE) : addr;
                stall     = ~(dmem_resp & ~is_ind);
                if (is_str) begin
                    dmem_write       = 1'b1;
                    dmem_byte_enable = 2'b11;
                    dmem_wdata       = store_data;
                end else if (is_stb) begin
                    dmem_write       = 1'b1;
                    dmem_byte_enable = addr[0] ? 2'b10 : 2'b01;
                    dmem_wdata       = {store_data[7:0], store_data[7:0]};
                end else begin
                    dmem_read = 1'b1;
                end
            end
            StAcc2: begin
                dmem_addr = ptr_q & 16'hFFFE;
                stall     = ~dmem_resp;
                if (is_sti) begin
                    dmem_write       = 1'b1;
                    dmem_byte_enable = 2'b11;
                    dmem_wdata       = store_data;
                end else begin
                    dmem_read = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            ptr_q         <= 16'h0000;
            wb_valid_q    <= 1'b0;
            wb_dest_q     <= 3'd0;
            wb_data_q     <= 16'h0000;
            wb_regwrite_q <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (valid_in) begin
                        if (is_mem) begin
                            state_q <= StAcc1;
                        end else begin
                            wb_valid_q    <= 1'b1;
                            wb_dest_q     <= dest_in;
                            wb_data_q     <= ex_result;
                            wb_regwrite_q <= ~no_regwrite;
                        end
                    end
                end
                StAcc1: begin
                    if (dmem_resp) begin
                        if (is_ind) begin
                            ptr_q   <= dmem_rdata;
                            state_q <= StAcc2;
                        end else begin
                            state_q       <= StIdle;
                            wb_valid_q    <= 1'b1;
                            wb_dest_q     <= dest_in;
                            wb_regwrite_q <= is_load;
                            wb_data_q     <= is_ldb ? ldb_byte : (is_load ? dmem_rdata : 16'h0000);
                        end
                    end
                end
                StAcc2: begin
                    if (dmem_resp) begin
                        state_q       <= StIdle;
                        wb_valid_q    <= 1'b1;
                        wb_dest_q     <= dest_in;
                        wb_regwrite_q <= is_ldi;
                        wb_data_q     <= is_ldi ? dmem_rdata : 16'h0000;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wb_valid    = wb_valid_q;
    assign wb_dest     = wb_dest_q;
    assign wb_data     = wb_data_q;
    assign wb_regwrite = wb_regwrite_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random instructions checked against an
// access-list model derived from the LC-3b memory-stage rules.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [3:0]  opcode;
    logic [15:0] addr;
    logic [15:0] store_data;
    logic [15:0] ex_result;
    logic [2:0]  dest_in;
    logic        dmem_resp;
    logic [15:0] dmem_rdata;
    logic        dmem_read;
    logic        dmem_write;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [1:0]  dmem_byte_enable;
    logic        stall;
    logic        wb_valid;
    logic [2:0]  wb_dest;
    logic [15:0] wb_data;
    logic        wb_regwrite;

    int checks   = 0;
    int failures = 0;

    mem_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid_in         (valid_in),
        .opcode           (opcode),
        .addr             (addr),
        .store_data       (store_data),
        .ex_result        (ex_result),
        .dest_in          (dest_in),
        .dmem_resp        (dmem_resp),
        .dmem_rdata       (dmem_rdata),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .stall            (stall),
        .wb_valid         (wb_valid),
        .wb_dest          (wb_dest),
        .wb_data          (wb_data),
        .wb_regwrite      (wb_regwrite)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One instruction end to end: the expected access list and writeback are built first
    // from the opcode rules, then the memory side is played with the requested wait counts.
    task automatic run_instr(input logic [3:0] op, input logic [15:0] a, input logic [15:0] sd,
                             input logic [15:0] exr, input logic [2:0] dst, input int w1,
                             input int w2, input logic [15:0] rd1, input logic [15:0] rd2);
        logic        mem, ind, ld, st;
        int          nacc;
        logic [15:0] ea [2];
        logic        ew [2];
        logic [1:0]  ebe [2];
        logic [15:0] ewd [2];
        int          ewait [2];
        logic [15:0] erd [2];
        logic [15:0] exp_data;
        logic        exp_rw;
        logic        rsp;
        mem  = op inside {4'b0110, 4'b0010, 4'b1010, 4'b0111, 4'b0011, 4'b1011};
        ind  = op inside {4'b1010, 4'b1011};
        ld   = op inside {4'b0110, 4'b0010, 4'b1010};
        st   = mem && !ld;
        nacc = !mem ? 0 : (ind ? 2 : 1);
        ewait[0] = w1; ewait[1] = w2; erd[0] = rd1; erd[1] = rd2;
        ea[0]  = (op == 4'b0010 || op == 4'b0011) ? a : {a[15:1], 1'b0};
        ew[0]  = (op == 4'b0111 || op == 4'b0011);
        ebe[0] = (op == 4'b0111) ? 2'b11 : (a[0] ? 2'b10 : 2'b01);
        ewd[0] = (op == 4'b0111) ? sd : {sd[7:0], sd[7:0]};
        ea[1]  = {rd1[15:1], 1'b0};
        ew[1]  = (op == 4'b1011);
        ebe[1] = 2'b11;
        ewd[1] = sd;
        if (!mem) begin
            exp_data = exr;
            exp_rw   = !(op inside {4'b0000, 4'b1100, 4'b1111});
        end else begin
            exp_rw   = ld;
            exp_data = (op == 4'b0110) ? rd1 : (op == 4'b1010) ? rd2 :
                       (a[0] ? {8'h00, rd1[15:8]} : {8'h00, rd1[7:0]});
        end

        @(posedge clk); #1;
        valid_in = 1'b1; opcode = op; addr = a; store_data = sd; ex_result = exr;
        dest_in = dst; dmem_resp = 1'b0;
        #3;
        chk("present_stall", {15'h0, stall}, {15'h0, mem});
        chk("present_strobes", {14'h0, dmem_read, dmem_write}, 16'h0);
        for (int k = 0; k < nacc; k++) begin
            for (int c = 0; c <= ewait[k]; c++) begin
                @(posedge clk); #1;
                rsp = (c == ewait[k]);
                dmem_resp  = rsp;
                dmem_rdata = rsp ? erd[k] : 16'($urandom);
                #3;
                chk("acc_read", {15'h0, dmem_read}, {15'h0, !ew[k]});
                chk("acc_write", {15'h0, dmem_write}, {15'h0, ew[k]});
                chk("acc_addr", dmem_addr, ea[k]);
                if (ew[k]) begin
                    chk("acc_be", {14'h0, dmem_byte_enable}, {14'h0, ebe[k]});
                    chk("acc_wdata", dmem_wdata, ewd[k]);
                end
                chk("acc_stall", {15'h0, stall}, {15'h0, !(rsp && k == nacc - 1)});
                chk("acc_wb_quiet", {15'h0, wb_valid}, 16'h0);
            end
        end
        @(posedge clk); #1;
        valid_in   = 1'b0;
        dmem_resp  = 1'($urandom_range(0, 1));
        dmem_rdata = 16'($urandom);
        #3;
        chk("wb_valid", {15'h0, wb_valid}, 16'h1);
        chk("wb_dest", {13'h0, wb_dest}, {13'h0, dst});
        chk("wb_regwrite", {15'h0, wb_regwrite}, {15'h0, exp_rw});
        if (!st) chk("wb_data", wb_data, exp_data);
        chk("done_stall", {15'h0, stall}, 16'h0);
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        #3;
        chk("wb_once", {15'h0, wb_valid}, 16'h0);
        chk("idle_strobes", {14'h0, dmem_read, dmem_write}, 16'h0);
    endtask

    initial begin
        rst_n = 1'b0; valid_in = 1'b0; opcode = 4'h0; addr = 16'h0; store_data = 16'h0;
        ex_result = 16'h0; dest_in = 3'd0; dmem_resp = 1'b0; dmem_rdata = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", {15'h0, wb_valid}, 16'h0);
        chk("rst_wb_data", wb_data, 16'h0);
        chk("rst_outputs", {10'h0, dmem_read, dmem_write, dmem_byte_enable, stall, wb_regwrite},
            16'h0);
        rst_n = 1'b1;

        run_instr(4'b0001, 16'h0000, 16'h0000, 16'h1234, 3'd3, 0, 0, 16'h0, 16'h0);   // ADD
        run_instr(4'b0010, 16'h3001, 16'h0000, 16'h0000, 3'd1, 2, 0, 16'hABCD, 16'h0); // LDB
        run_instr(4'b0011, 16'h4000, 16'h1277, 16'h0000, 3'd2, 1, 0, 16'h0, 16'h0);   // STB
        run_instr(4'b1010, 16'h5001, 16'h0000, 16'h0000, 3'd4, 0, 1, 16'h6003, 16'hBEEF);
        run_instr(4'b1011, 16'h2000, 16'h55AA, 16'h0000, 3'd5, 1, 2, 16'h7000, 16'h0);
        run_instr(4'b0000, 16'h0000, 16'h0000, 16'h9999, 3'd6, 0, 0, 16'h0, 16'h0);   // BR

        // Reset while the LDI is in its second access.
        @(posedge clk); #1;
        valid_in = 1'b1; opcode = 4'b1010; addr = 16'h5001; dest_in = 3'd7; dmem_resp = 1'b0;
        @(posedge clk); #1;
        dmem_resp = 1'b1; dmem_rdata = 16'h6003;
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        #2;
        chk("acc2_before_rst_read", {15'h0, dmem_read}, 16'h1);
        chk("acc2_before_rst_addr", dmem_addr, 16'h6002);
        rst_n = 1'b0;
        #1;
        chk("midrst_strobes", {14'h0, dmem_read, dmem_write}, 16'h0);
        chk("midrst_stall", {15'h0, stall}, 16'h0);
        chk("midrst_addr", dmem_addr, 16'h0);
        chk("midrst_wb_valid", {15'h0, wb_valid}, 16'h0);
        valid_in = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        dmem_resp = 1'b1; dmem_rdata = 16'hBEEF;
        @(posedge clk); #3;
        chk("postrst_no_resume_read", {15'h0, dmem_read}, 16'h0);
        chk("postrst_no_wb", {15'h0, wb_valid}, 16'h0);
        dmem_resp = 1'b0;
        run_instr(4'b0001, 16'h0000, 16'h0000, 16'h4321, 3'd2, 0, 0, 16'h0, 16'h0);

        for (int n = 0; n < 40; n++) begin
            run_instr(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 16'($urandom),
                      3'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
